// File: rtl/status_light_responder.sv
// Query endpoint: accepts a 3-word "GET /STATUS_LIGHT\n" request and answers
// with a single ON/OFF word, or ERR when the frame is malformed.
//
// state  | meaning
// S_IDLE | waiting for the first request word
// S_W1   | first word matched, waiting for the second
// S_W2   | second word matched, waiting for the third
// S_RESP | response word held on eth_tx_* until the handshake completes
module status_light_responder #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [47:0]      eth_rx_data,
  input  logic             eth_rx_valid,
  output logic             eth_rx_ready,
  output logic [47:0]      eth_tx_data,
  output logic             eth_tx_valid,
  input  logic             eth_tx_ready,
  input  logic             light_on,
  output logic [CNT_W-1:0] req_count,
  output logic             timeout_err
);

  localparam logic [47:0] REQ_W0   = 48'h474554202F53;
  localparam logic [47:0] REQ_W1   = 48'h54415455535F;
  localparam logic [47:0] REQ_W2   = 48'h4C494748540A;
  localparam logic [47:0] RESP_ON  = 48'h000000004F4E;
  localparam logic [47:0] RESP_OFF = 48'h0000004F4646;
  localparam logic [47:0] RESP_ERR = 48'h000000455252;

  // A zero TIMEOUT_CYCLES disables the timer; keep it one bit wide in that case.
  localparam int             TMR_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit             TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_W1, S_W2, S_RESP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_rx_ready;
  logic               r_tx_valid;
  logic [47:0]        r_tx_data;
  logic [47:0]        w_next_data;
  logic               r_resp_ok;
  logic               w_next_ok;
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_next;
  logic               r_timeout;
  logic               w_timeout;
  logic [CNT_W-1:0]   r_req_count;
  logic               w_accept;
  logic               w_send;

  assign w_accept = eth_rx_valid & r_rx_ready;
  assign w_send   = r_tx_valid & eth_tx_ready;

  always_comb begin
    w_next       = r_state;
    w_next_data  = r_tx_data;
    w_next_ok    = r_resp_ok;
    w_timer_next = '0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (eth_rx_data == REQ_W0) begin
            w_next = S_W1;
          end else begin
            w_next      = S_RESP;
            w_next_data = RESP_ERR;
            w_next_ok   = 1'b0;
          end
        end
      end
      S_W1, S_W2: begin
        if (w_accept) begin
          if (r_state == S_W1 && eth_rx_data == REQ_W1) begin
            w_next = S_W2;
          end else if (r_state == S_W2 && eth_rx_data == REQ_W2) begin
            w_next      = S_RESP;
            w_next_data = light_on ? RESP_ON : RESP_OFF;
            w_next_ok   = 1'b1;
          end else begin
            w_next      = S_RESP;
            w_next_data = RESP_ERR;
            w_next_ok   = 1'b0;
          end
        end else if (TMO_EN && r_timer == TMR_LAST) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      S_RESP: begin
        if (w_send) begin
          w_next      = S_IDLE;
          w_next_data = '0;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rx_ready  <= 1'b1;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_resp_ok   <= 1'b0;
      r_timer     <= '0;
      r_timeout   <= 1'b0;
      r_req_count <= '0;
    end else begin
      r_state    <= w_next;
      r_rx_ready <= (w_next != S_RESP);
      r_tx_valid <= (w_next == S_RESP);
      r_tx_data  <= w_next_data;
      r_resp_ok  <= w_next_ok;
      r_timer    <= w_timer_next;
      r_timeout  <= w_timeout;
      if (w_send && r_resp_ok) begin
        r_req_count <= r_req_count + 1'b1;
      end
    end
  end

  assign eth_rx_ready = r_rx_ready;
  assign eth_tx_valid = r_tx_valid;
  assign eth_tx_data  = r_tx_data;
  assign req_count    = r_req_count;
  assign timeout_err  = r_timeout;

endmodule
